// File: rtl/ita_oup_writer.sv
// Output writer: buffers accelerator words in a 2-entry FIFO and writes them to tiled addresses (column outer, row inner).
// Latency: accept at edge k -> mem_req_o in cycle k+1; 1 word/cycle under constant grant. Backpressure: ready_o drops when the FIFO is full.
// Optional ITA_OUP_WRITER_PERF_EN adds a saturating stall_cnt_o (cycles with a request but no grant).
module ita_oup_writer #(
    parameter int unsigned N          = 16,
    parameter int unsigned WI         = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    input  logic [CNT_WIDTH-1:0]  rows_i,
    input  logic [CNT_WIDTH-1:0]  tiles_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [N*WI-1:0]       data_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [N*WI-1:0]       mem_wdata_o,
    output logic [N-1:0]          mem_be_o,
    output logic                  busy_o,
    output logic                  done_o
`ifdef ITA_OUP_WRITER_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [ADDR_WIDTH-1:0] TILE_BYTES = ADDR_WIDTH'(N);
    localparam logic [CNT_WIDTH-1:0]  ONE        = CNT_WIDTH'(1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] row_ptr_q;
    logic [ADDR_WIDTH-1:0] col_base_q;
    logic [CNT_WIDTH-1:0]  rows_q;
    logic [CNT_WIDTH-1:0]  tiles_q;
    logic [CNT_WIDTH-1:0]  in_row_q;
    logic [CNT_WIDTH-1:0]  in_tile_q;
    logic [CNT_WIDTH-1:0]  out_row_q;
    logic [N*WI-1:0]       fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            fifo_cnt_q;
    logic [1:0]            fifo_cnt_d;

    logic                  push;
    logic                  pop;
    logic                  last_in;
    logic [CNT_WIDTH-1:0]  rows_m1;
    logic [CNT_WIDTH-1:0]  tiles_m1;

    assign rows_m1  = rows_q - ONE;
    assign tiles_m1 = tiles_q - ONE;
    assign push     = valid_i && ready_o;
    assign pop      = mem_req_o && mem_gnt_i;
    assign last_in  = (in_row_q == rows_m1) && (in_tile_q == tiles_m1);

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            stride_q   <= '0;
            row_ptr_q  <= '0;
            col_base_q <= '0;
            rows_q     <= '0;
            tiles_q    <= '0;
            in_row_q   <= '0;
            in_tile_q  <= '0;
            out_row_q  <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= data_i;
                wr_ptr_q         <= ~wr_ptr_q;
                if (in_row_q == rows_m1) begin
                    in_row_q  <= '0;
                    in_tile_q <= in_tile_q + ONE;
                end else begin
                    in_row_q <= in_row_q + ONE;
                end
            end
            // Address pointer follows the FIFO head, so it moves only on a grant.
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
                if (out_row_q == rows_m1) begin
                    out_row_q  <= '0;
                    col_base_q <= col_base_q + TILE_BYTES;
                    row_ptr_q  <= col_base_q + TILE_BYTES;
                end else begin
                    out_row_q <= out_row_q + ONE;
                    row_ptr_q <= row_ptr_q + stride_q;
                end
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        stride_q   <= stride_i;
                        rows_q     <= rows_i;
                        tiles_q    <= tiles_i;
                        row_ptr_q  <= base_addr_i;
                        col_base_q <= base_addr_i;
                        in_row_q   <= '0;
                        in_tile_q  <= '0;
                        out_row_q  <= '0;
                        state_q    <= (rows_i == '0 || tiles_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push && last_in) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_cnt_d == 2'd0) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Leaving RUN on the last accept keeps ready_o low once the job's words are in.
    assign ready_o     = (state_q == RUN) && (fifo_cnt_q != 2'd2);
    assign mem_req_o   = (fifo_cnt_q != 2'd0);
    assign mem_addr_o  = row_ptr_q;
    assign mem_wdata_o = fifo_q[rd_ptr_q];
    assign mem_be_o    = {N{mem_req_o}};
    assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
    assign done_o      = (state_q == DONE);

`ifdef ITA_OUP_WRITER_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            stall_cnt_q <= '0;
        end else if (mem_req_o && !mem_gnt_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ita_oup_writer.sv
// Bench for ita_oup_writer: directed jobs with random data/handshakes against an address/data queue model.
module tb_ita_oup_writer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [31:0]  base_addr_i;
    logic [31:0]  stride_i;
    logic [15:0]  rows_i;
    logic [15:0]  tiles_i;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] data_i;
    logic         mem_req_o;
    logic         mem_gnt_i;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [15:0]  mem_be_o;
    logic         busy_o;
    logic         done_o;
`ifdef ITA_OUP_WRITER_PERF_EN
    logic [31:0]  stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    ita_oup_writer dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .rows_i      (rows_i),
        .tiles_i     (tiles_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef ITA_OUP_WRITER_PERF_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_req"},   mem_req_o, 0);
        chk({tag, "_addr"},  mem_addr_o, 0);
        chk({tag, "_wdata"}, mem_wdata_o, 0);
        chk({tag, "_be"},    mem_be_o, 0);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_done"},  done_o, 0);
`ifdef ITA_OUP_WRITER_PERF_EN
        chk({tag, "_stall"}, stall_cnt_o, 0);
`endif
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one job cycle by cycle; cycle 0 is the start cycle. Returns the cycle done_o was seen in.
    task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                           input logic [15:0] rows, input logic [15:0] tiles,
                           input int vld_pct, input int gnt_pct,
                           input int stall_from, input int stall_len,
                           input int restart_at, output int done_c);
        logic [31:0]  exp_addr[$];
        logic [127:0] exp_dat[$];
        logic [31:0]  hold_a = '0;
        logic [127:0] hold_d = '0;
        bit hold_v = 0;
        bit nz, e_ready, e_done, e_busy, acc_ev, gnt_ev;
        int total, acc = 0, grants = 0, level = 0, g_last = -10, c = 0, stalls = 0;

        total = int'(rows) * int'(tiles);
        nz = (total != 0);
        for (int t = 0; t < int'(tiles); t++)
            for (int r = 0; r < int'(rows); r++)
                exp_addr.push_back(base + 32'(r) * stride + 32'(t * 16));
        done_c = -1;

        @(posedge clk_i); #1;
        start_i = 1; base_addr_i = base; stride_i = stride; rows_i = rows; tiles_i = tiles;
        valid_i = 0; data_i = rnd128();
        mem_gnt_i = ($urandom_range(99) < gnt_pct);

        while (c < 400) begin
            @(negedge clk_i);
            e_ready = nz && c >= 1 && acc < total && level < 2;
            e_done  = nz ? (grants == total && c == g_last + 1) : (c == 1);
            e_busy  = nz && c >= 1 && !(grants == total && c > g_last);
            chk("ready", ready_o, e_ready);
            chk("req", mem_req_o, level > 0);
            chk("be", mem_be_o, {16{mem_req_o}});
            chk("done", done_o, e_done);
            chk("busy", busy_o, e_busy);
            if (hold_v) begin
                chk("hold_req", mem_req_o, 1);
                chk("hold_addr", mem_addr_o, hold_a);
                chk("hold_data", mem_wdata_o, hold_d);
            end
            if (done_o && done_c < 0) done_c = c;

            gnt_ev = mem_req_o && mem_gnt_i;
            acc_ev = valid_i && ready_o;
            hold_v = 0;
            if (gnt_ev) begin
                chk("write_in_range", grants < total, 1);
                if (exp_addr.size() > 0) chk("wr_addr", mem_addr_o, exp_addr.pop_front());
                if (exp_dat.size() > 0)  chk("wr_data", mem_wdata_o, exp_dat.pop_front());
                grants++;
                if (grants == total) g_last = c;
            end else if (mem_req_o) begin
                hold_v = 1; hold_a = mem_addr_o; hold_d = mem_wdata_o;
                stalls++;
            end
            if (acc_ev) begin
                exp_dat.push_back(data_i);
                acc++;
            end
            level = level + int'(acc_ev) - int'(gnt_ev);
            if (done_c >= 0 && c >= done_c + 2) break;

            @(posedge clk_i); #1;
            c++;
            start_i = (c == restart_at);
            base_addr_i = $urandom; stride_i = $urandom;
            rows_i = 16'($urandom_range(1, 7)); tiles_i = 16'($urandom_range(1, 7));
            if (!(valid_i && !acc_ev)) begin
                valid_i = ($urandom_range(99) < vld_pct);
                data_i  = rnd128();
            end
            mem_gnt_i = (c >= stall_from && c < stall_from + stall_len) ? 1'b0
                      : ($urandom_range(99) < gnt_pct);
        end

        chk("done_seen", done_c >= 0, 1);
        chk("grant_total", grants, total);
        chk("accept_total", acc, total);
        chk("addr_left", exp_addr.size(), 0);
`ifdef ITA_OUP_WRITER_PERF_EN
        chk("stall_cnt", stall_cnt_o, stalls);
`endif
        start_i = 0; valid_i = 0; mem_gnt_i = 0;
    endtask

    initial begin
        int dc;
        rst_ni = 0; start_i = 0; base_addr_i = 0; stride_i = 0; rows_i = 0; tiles_i = 0;
        valid_i = 0; data_i = 0; mem_gnt_i = 0;
        #3;
        chk_outputs_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1;

        // Basic tiled order and latency
        run_job(32'h1000, 32'h40, 16'd3, 16'd2, 100, 100, 999, 0, -1, dc);
        chk("basic_start_to_done", dc, 8);

        // Memory stall with continuous valid
        run_job(32'h2000, 32'h80, 16'd4, 16'd2, 100, 100, 2, 5, -1, dc);
`ifdef ITA_OUP_WRITER_PERF_EN
        chk("stall_cnt_5", stall_cnt_o, 5);
`endif

        // Zero-size job
        run_job(32'h3000, 32'h40, 16'd0, 16'd4, 100, 100, 999, 0, -1, dc);
        chk("zero_start_to_done", dc, 1);

        // Address wrap
        run_job(32'hFFFF_FFF0, 32'h10, 16'd2, 16'd1, 100, 100, 999, 0, -1, dc);

        // Start during RUN is ignored
        run_job(32'h4000, 32'h100, 16'd3, 16'd3, 80, 70, 999, 0, 3, dc);

        // Reset with one word buffered
        @(posedge clk_i); #1;
        start_i = 1; base_addr_i = 32'h5000; stride_i = 32'h20; rows_i = 16'd4; tiles_i = 16'd1;
        @(posedge clk_i); #1;
        start_i = 0; valid_i = 1; data_i = 128'hDEAD_BEEF;
        @(posedge clk_i); #1;
        valid_i = 0;
        @(negedge clk_i);
        chk("pre_reset_req", mem_req_o, 1);
        #2 rst_ni = 0;
        #1 chk_outputs_zero("async_reset");
        @(posedge clk_i); #1;
        rst_ni = 1;
        run_job(32'h6000, 32'h30, 16'd2, 16'd2, 100, 100, 999, 0, -1, dc);
        chk("post_reset_start_to_done", dc, 6);

        // Randomized jobs
        for (int k = 0; k < 4; k++)
            run_job($urandom, $urandom, 16'($urandom_range(1, 5)), 16'($urandom_range(1, 4)),
                    70, 60, 999, 0, -1, dc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
